shift_reg_piso_param: RTL
=========================

SHIFT_REG_PISO_PARAM -- requirements
Module: shift_reg_piso_param

Interface
REQ-001 Parameter WIDTH, default 8: shift word width in bits; the block SHALL support any WIDTH >= 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 shifts left (MSB out first), 0 shifts right (LSB out first).
REQ-003 Parameter IDLE_LEVEL, default 0: value driven on DatOut when not shifting.
REQ-004 clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low: rst=0 sampled on a clk rising edge resets the block.
REQ-006 ena  input  1  shift-enable tick; one bit is shifted per cycle with ena=1 while busy.
REQ-007 load  input  1  start request; parallel-loads DatIn when idle.
REQ-008 clr  input  1  synchronous abort of a transfer in progress.
REQ-009 DatIn  input  WIDTH  parallel transmit word.
REQ-010 SerIn  input  1  serial receive bit, sampled on each shift.
REQ-011 DatOut  output  1  serial transmit bit.
REQ-012 DatRx  output  WIDTH  last completely received word.
REQ-013 busy  output  1  high while a transfer is in progress.
REQ-014 done  output  1  one-cycle pulse at transfer completion.

Function
REQ-015 The block SHALL implement two states: IDLE and SHIFT; all outputs SHALL be registered or decoded from registered state only.
REQ-016 IDLE: busy=0; DatOut=IDLE_LEVEL; ena SHALL be ignored.
REQ-017 IDLE with load=1 at edge n: shift register <= DatIn, bit counter <= 0, state -> SHIFT; from cycle n+1 busy=1 and DatOut = first bit (DatIn[WIDTH-1] if MSB_FIRST else DatIn[0]).
REQ-018 SHIFT with ena=1: MSB_FIRST=1 -> register <= {reg[WIDTH-2:0], SerIn}; MSB_FIRST=0 -> register <= {SerIn, reg[WIDTH-1:1]}; counter += 1.
REQ-019 SHIFT: DatOut SHALL equal reg[WIDTH-1] (MSB_FIRST=1) or reg[0] (MSB_FIRST=0).
REQ-020 SHIFT with ena=0: register and counter SHALL hold.
REQ-021 The shift with ena=1 that brings the counter to WIDTH at edge m SHALL cause, at cycle m+1: state IDLE, busy=0, done=1, DatRx = post-shift register contents, DatOut=IDLE_LEVEL.
REQ-022 done SHALL be high for exactly one cycle per completed transfer and SHALL never assert on abort or reset.
REQ-023 Counter width SHALL be $clog2(WIDTH+1); counter SHALL never exceed WIDTH.
REQ-024 load while in SHIFT SHALL be ignored; current transfer continues unchanged.
REQ-025 load in the cycle done=1 (state already IDLE) SHALL be accepted, giving back-to-back transfers with one idle cycle between them.
REQ-026 load and ena both 1 in IDLE: load only; no shift occurs in that cycle.
REQ-027 clr=1 in SHIFT: state -> IDLE next cycle, busy=0, done=0, DatRx unchanged, counter <= 0; clr has priority over ena.
REQ-028 clr=1 in IDLE: no effect; clr and load both 1 in IDLE: clr wins, load ignored.
REQ-029 DatRx SHALL change only on completion (REQ-021) or reset.

Reset
REQ-030 rst=0 at a rising edge SHALL force: state IDLE, shift register 0, counter 0, DatRx 0, busy 0, done 0, DatOut IDLE_LEVEL.
REQ-031 Reset SHALL take priority over load, ena and clr, including mid-transfer; no done pulse SHALL result.
REQ-032 rst=1 with no load SHALL leave the block in IDLE indefinitely.

Verification
REQ-033 WIDTH=8, MSB_FIRST=1: load DatIn=8'hA5, 8 consecutive ena, SerIn sequence 1,1,0,0,0,0,1,1 -> DatOut 1,0,1,0,0,1,0,1; done one cycle after 8th ena; DatRx=8'hC3.
REQ-034 WIDTH=8, MSB_FIRST=0: load 8'hA5, SerIn tied 0 -> DatOut 1,0,1,0,0,1,0,1; DatRx=8'h00.
REQ-035 ena gapped (every 3rd cycle), 8'h3C loaded -> identical bit order; busy high throughout; exactly one done pulse.
REQ-036 load=1 held during transfer of 8'hF0 with DatIn changed to 8'h0F -> 8'hF0 shifted unaltered; load in done cycle starts 8'h0F transfer.
REQ-037 clr after 4 shifts -> busy=0 next cycle, no done, DatRx keeps prior value; rst=0 after 5 shifts -> all outputs at reset values, no done.
REQ-038 WIDTH=16 build: load 16'h8001, 16 ena -> DatOut 1, fourteen 0s, 1; counter never exceeds 16.

Source files
------------

// File: rtl/shift_reg_piso_param.sv
// Parameterised PISO transmit shifter that captures a receive word from SerIn in the same shift chain.
// load starts a WIDTH-bit transfer, ena clocks one bit per cycle, clr aborts it, and done pulses on completion.
module shift_reg_piso_param #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0,
  localparam int CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             load,
  input  logic             clr,
  input  logic [WIDTH-1:0] DatIn,
  input  logic             SerIn,
  output logic             DatOut,
  output logic [WIDTH-1:0] DatRx,
  output logic             busy,
  output logic             done,
  output logic             dbg_state,
  output logic [CW-1:0]    dbg_cnt
);

  // Handshake: load is a request that is taken only in a cycle where busy=0 and clr=0;
  // after that, busy stays high until done pulses (completion) or clr/reset aborts the transfer.
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n, shifted;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] datrx_n;
  logic             done_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      DatRx <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      cnt   <= cnt_n;
      DatRx <= datrx_n;
      done  <= done_n;
    end
  end

  always_comb begin
    shifted = sreg;
    if (MSB_FIRST) shifted = {sreg[WIDTH-2:0], SerIn};
    else           shifted = {SerIn, sreg[WIDTH-1:1]};
  end

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    datrx_n = DatRx;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        // clr beats load here; ena has no meaning while idle.
        if (!clr && load) begin
          sreg_n  = DatIn;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (clr) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (ena) begin
          sreg_n = shifted;
          cnt_n  = cnt + CW'(1);
          if (cnt == LAST_CNT) begin
            state_n = IDLE;
            done_n  = 1'b1;
            datrx_n = shifted;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state == SHIFT);
  assign DatOut    = busy ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : IDLE_LEVEL;
  assign dbg_state = state;
  assign dbg_cnt   = cnt;

endmodule
